// File: rtl/axi_read_burst_scheduler.sv
// axi_read_burst_scheduler: round-robin sharing of one burst read engine with a timeout watchdog
module axi_read_burst_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_BYTES = 512,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  output logic                          RSP_ERROR,
  output logic                          ENG_START,
  output logic                          ENG_ABORT,
  output logic [ADDR_WIDTH-1:0]         ENG_ADDR,
  input  logic                          ENG_DONE,
  input  logic                          ENG_ERROR,
  output logic                          BUSY,
  output logic [GW-1:0]                 GRANT_ID
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [GW-1:0] ptr, ptr_n, pick, grant_n;
  logic found, aligned, bad, bad_n, err_n, start_n, abort_n;
  logic [ADDR_WIDTH-1:0] pick_addr, eng_addr_n;
  logic [NUM_REQ-1:0] ready_n, rsp_n;
  logic [CW-1:0] cnt, cnt_n;
  int j;
  always_comb begin
    found = 1'b0;
    pick = '0;
    j = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (!found && REQ_VALID[j[GW-1:0]]) begin
        found = 1'b1;
        pick = j[GW-1:0];
      end
    end
  end
  assign pick_addr = REQ_ADDR[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
  assign aligned = (pick_addr & ADDR_WIDTH'(BURST_BYTES - 1)) == '0;
  // Outputs are computed for the state being entered, so every output is a register.
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    grant_n = GRANT_ID;
    bad_n = bad;
    cnt_n = cnt;
    eng_addr_n = ENG_ADDR;
    ready_n = '0;
    rsp_n = '0;
    err_n = 1'b0;
    start_n = 1'b0;
    abort_n = 1'b0;
    case (state)
      IDLE: if (found) begin
        state_n = ISSUE;
        grant_n = pick;
        bad_n = !aligned;
        ready_n[pick] = 1'b1;
        start_n = aligned;
        eng_addr_n = aligned ? pick_addr : ENG_ADDR;
      end
      ISSUE: begin
        ptr_n = GRANT_ID == GW'(NUM_REQ - 1) ? '0 : GRANT_ID + 1'b1;
        state_n = bad ? RESP : WAIT;
        // The start cycle counts, so the registered abort lands TIMEOUT_CYCLES after ENG_START.
        cnt_n = CW'(1);
        rsp_n[GRANT_ID] = bad;
        err_n = bad;
      end
      WAIT: if (ENG_DONE || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        state_n = RESP;
        rsp_n[GRANT_ID] = 1'b1;
        err_n = !ENG_DONE || ENG_ERROR;
        abort_n = !ENG_DONE;
      end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state <= IDLE;
      ptr <= '0;
      bad <= 1'b0;
      cnt <= '0;
      GRANT_ID <= '0;
      ENG_ADDR <= '0;
      REQ_READY <= '0;
      RSP_VALID <= '0;
      RSP_ERROR <= 1'b0;
      ENG_START <= 1'b0;
      ENG_ABORT <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      bad <= bad_n;
      cnt <= cnt_n;
      GRANT_ID <= grant_n;
      ENG_ADDR <= eng_addr_n;
      REQ_READY <= ready_n;
      RSP_VALID <= rsp_n;
      RSP_ERROR <= err_n;
      ENG_START <= start_n;
      ENG_ABORT <= abort_n;
      BUSY <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_axi_read_burst_scheduler.sv
// tb_axi_read_burst_scheduler: vector table, corner sequences and random transactions vs a timeline model
module tb_axi_read_burst_scheduler;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic M_AXI_ARESET, ENG_DONE, ENG_ERROR, RSP_ERROR, ENG_START, ENG_ABORT, BUSY;
  logic [1:0] REQ_VALID, REQ_READY, RSP_VALID;
  logic [63:0] REQ_ADDR;
  logic [31:0] ENG_ADDR;
  logic [0:0] GRANT_ID;
  int n_cmp = 0, n_bad = 0;
  int mptr = 0;
  logic [1:0] pend = '0;
  logic [31:0] paddr [2];
  logic [31:0] xaddr = '0;
  typedef struct {
    logic [1:0] add;
    logic [31:0] a0, a1;
    int d;
    bit e;
    int xg;
    bit xe;
  } vec_t;
  vec_t tbl [13];

  axi_read_burst_scheduler #(.NUM_REQ(2), .ADDR_WIDTH(32), .BURST_BYTES(512), .TIMEOUT_CYCLES(TO)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_ERROR(RSP_ERROR), .ENG_START(ENG_START),
    .ENG_ABORT(ENG_ABORT), .ENG_ADDR(ENG_ADDR), .ENG_DONE(ENG_DONE), .ENG_ERROR(ENG_ERROR),
    .BUSY(BUSY), .GRANT_ID(GRANT_ID)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [40:0] outs();
    return {REQ_READY, RSP_VALID, RSP_ERROR, ENG_START, ENG_ABORT, BUSY, GRANT_ID, ENG_ADDR};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] x;
    x = $urandom & 32'hFFFF_FE00;
    if ($urandom_range(0, 3) == 0) x[8:0] = 9'($urandom_range(1, 511));
    return x;
  endfunction

  // One grant/response transaction; the expected timeline is derived from the engine delay d.
  task automatic run_txn(input string nm, input logic [1:0] add, input logic [31:0] a0, input logic [31:0] a1,
                         input int d, input bit e, output int og, output bit oerr);
    int g, r;
    bit al, xerr;
    logic [40:0] xv;
    if (add[0] && !pend[0]) paddr[0] = a0;
    if (add[1] && !pend[1]) paddr[1] = a1;
    pend = pend | add;
    if (pend == 2'b00) begin
      pend[0] = 1'b1;
      paddr[0] = a0;
    end
    g = pend[mptr] ? mptr : 1 - mptr;
    al = paddr[g][8:0] == 9'd0;
    r = !al ? 2 : (d <= TO - 1 ? d + 2 : TO + 1);
    xerr = !al || d > TO - 1 || e;
    og = -1;
    oerr = 1'b0;
    REQ_VALID = pend;
    REQ_ADDR = {paddr[1], paddr[0]};
    for (int c = 1; c <= r + 1; c++) begin
      step();
      if (c == 1) begin
        if (al) xaddr = paddr[g];
        og = int'(GRANT_ID);
      end
      if (c == r) oerr = RSP_ERROR;
      xv = {c == 1 ? 2'(1 << g) : 2'b00, c == r ? 2'(1 << g) : 2'b00, c == r && xerr, c == 1 && al,
            c == r && al && d > TO - 1, c <= r, 1'(g), xaddr};
      chk($sformatf("%s cycle %0d", nm, c), 64'(outs()), 64'(xv));
      if (c == 1) begin
        pend[g] = 1'b0;
        REQ_VALID = pend;
        mptr = (g + 1) % 2;
      end
      ENG_DONE = c == d + 1;
      ENG_ERROR = ENG_DONE ? e : 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int og;
    bit oe;
    tbl[0]  = '{2'b11, 32'h400, 32'h600, 3, 1'b0, 0, 1'b0};
    tbl[1]  = '{2'b00, 32'h0, 32'h0, 3, 1'b0, 1, 1'b0};
    tbl[2]  = '{2'b11, 32'h400, 32'h600, 3, 1'b0, 0, 1'b0};
    tbl[3]  = '{2'b00, 32'h0, 32'h0, 3, 1'b0, 1, 1'b0};
    tbl[4]  = '{2'b01, 32'h200, 32'h0, 12, 1'b0, 0, 1'b0};
    tbl[5]  = '{2'b10, 32'h0, 32'h102, 4, 1'b0, 1, 1'b1};
    tbl[6]  = '{2'b01, 32'h800, 32'h0, 16, 1'b0, 0, 1'b1};
    tbl[7]  = '{2'b10, 32'h0, 32'hA00, 2, 1'b0, 1, 1'b0};
    tbl[8]  = '{2'b01, 32'hC00, 32'h0, 5, 1'b1, 0, 1'b1};
    tbl[9]  = '{2'b10, 32'h0, 32'hE00, 15, 1'b0, 1, 1'b0};
    tbl[10] = '{2'b01, 32'h1000, 32'h0, 1, 1'b0, 0, 1'b0};
    tbl[11] = '{2'b11, 32'h1200, 32'h1401, 2, 1'b0, 1, 1'b1};
    tbl[12] = '{2'b00, 32'h0, 32'h0, 2, 1'b0, 0, 1'b0};
    paddr[0] = '0;
    paddr[1] = '0;
    M_AXI_ARESET = 1'b1;
    REQ_VALID = 2'b11;
    REQ_ADDR = '0;
    ENG_DONE = 1'b1;
    ENG_ERROR = 1'b0;
    step();
    step();
    chk("reset state", 64'(outs()), 64'd0);
    REQ_VALID = 2'b00;
    ENG_DONE = 1'b0;
    M_AXI_ARESET = 1'b0;
    step();
    chk("idle after reset", 64'(outs()), 64'd0);
    for (int i = 0; i < 13; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].add, tbl[i].a0, tbl[i].a1, tbl[i].d, tbl[i].e, og, oe);
      chk($sformatf("vec%0d grant", i), 64'(og), 64'(tbl[i].xg));
      chk($sformatf("vec%0d rsp_error", i), 64'(oe), 64'(tbl[i].xe));
    end
    ENG_DONE = 1'b1;
    step();
    ENG_DONE = 1'b0;
    step();
    chk("done ignored in idle", 64'(outs()), {23'd0, 41'({9'd0, 1'b0, xaddr})});
    REQ_VALID = 2'b01;
    REQ_ADDR = {32'h0, 32'h2000};
    step();
    REQ_VALID = 2'b00;
    step();
    step();
    M_AXI_ARESET = 1'b1;
    step();
    M_AXI_ARESET = 1'b0;
    chk("reset in wait", 64'(outs()), 64'd0);
    ENG_DONE = 1'b1;
    step();
    ENG_DONE = 1'b0;
    chk("no rsp after reset", 64'(outs()), 64'd0);
    step();
    chk("still idle after reset", 64'(outs()), 64'd0);
    mptr = 0;
    pend = 2'b00;
    xaddr = '0;
    run_txn("post reset", 2'b11, 32'h3000, 32'h3200, 4, 1'b0, og, oe);
    chk("post reset grant", 64'(og), 64'd0);
    for (int i = 0; i < 150; i++)
      run_txn($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), rand_addr(), rand_addr(),
              $urandom_range(1, TO + 1), 1'($urandom_range(0, 1)), og, oe);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
